tag_allocator: RTL and testbench

TAG_ALLOCATOR -- requirements
Module: tag_allocator

---
 rtl/tag_allocator_if.sv | 53 +++++
 rtl/tag_allocator.sv | 93 +++++++++
 tb/tb_tag_allocator.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/tag_allocator_if.sv
// -----------------------------------------------------------------------------
// tag_allocator_if
// Bundles the allocate handshake, the release port and the occupancy status of
// the tag allocator.
//   allocate_valid  (alloc -> user)  a free index is offered
//   allocate_ready  (user  -> alloc) the offered index is taken this edge
//   allocate_index  (alloc -> user)  lowest free index, 0 when full
//   release_enable  (user  -> alloc) return release_index to the pool
//   release_index   (user  -> alloc) index being returned
//   release_error   (alloc -> user)  previous-cycle release was illegal
//   used_count      (alloc -> user)  number of allocated indices
//   full / empty    (alloc -> user)  registered occupancy flags
// Modports: slave = allocator side, master = user side.
// -----------------------------------------------------------------------------
interface tag_allocator_if #(
    parameter int DEPTH       = 16,
    parameter int INDEX_WIDTH = $clog2(DEPTH),
    parameter int COUNT_WIDTH = $clog2(DEPTH + 1)
);
    logic                   allocate_valid;
    logic                   allocate_ready;
    logic [INDEX_WIDTH-1:0] allocate_index;
    logic                   release_enable;
    logic [INDEX_WIDTH-1:0] release_index;
    logic                   release_error;
    logic [COUNT_WIDTH-1:0] used_count;
    logic                   full;
    logic                   empty;

    modport slave (
        output allocate_valid,
        input  allocate_ready,
        output allocate_index,
        input  release_enable,
        input  release_index,
        output release_error,
        output used_count,
        output full,
        output empty
    );

    modport master (
        input  allocate_valid,
        output allocate_ready,
        input  allocate_index,
        output release_enable,
        output release_index,
        input  release_error,
        input  used_count,
        input  full,
        input  empty
    );
endinterface

// File: rtl/tag_allocator.sv
// -----------------------------------------------------------------------------
// tag_allocator
// Hands out indices 0..DEPTH-1 from a pool, lowest free index first, and takes
// them back on release. One "used" bit per index is the only pool state; the
// occupancy count and full/empty flags are kept as registers alongside it.
// Ports:
//   clock  rising-edge clock
//   reset  asynchronous active-high reset
//   bus    tag_allocator_if.slave (allocate handshake, release port, status)
// -----------------------------------------------------------------------------
module tag_allocator #(
    parameter int DEPTH       = 16,
    parameter int INDEX_WIDTH = $clog2(DEPTH),
    parameter int COUNT_WIDTH = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    tag_allocator_if.slave   bus
);

    logic [DEPTH-1:0]       used_q, used_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic                   full_q, full_d;
    logic                   empty_q, empty_d;
    logic                   rel_err_q, rel_err_d;

    logic                   free_found;
    logic [INDEX_WIDTH-1:0] lowest_free;
    logic                   rel_hit;
    logic                   xfer;
    logic                   rel_legal;
    logic [DEPTH-1:0]       alloc_mask;
    logic [DEPTH-1:0]       rel_mask;

    // Priority search from the top down so the last hit is the lowest free
    // index. The release lookup matches by value rather than indexing used_q,
    // so an out-of-range release_index simply finds no used bit.
    always_comb begin
        free_found  = 1'b0;
        lowest_free = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!used_q[i]) begin
                free_found  = 1'b1;
                lowest_free = INDEX_WIDTH'(i);
            end
        end
        rel_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (bus.release_index == INDEX_WIDTH'(i)) begin
                rel_hit = used_q[i];
            end
        end
    end

    // Both decisions use the pre-edge used_q: a release of an index that is
    // being handed out in the same cycle sees it free and is rejected, and a
    // released index is only offered from the following cycle.
    always_comb begin
        xfer       = free_found & bus.allocate_ready;
        rel_legal  = bus.release_enable & rel_hit;
        rel_err_d  = bus.release_enable & ~rel_hit;
        alloc_mask = {{(DEPTH-1){1'b0}}, xfer} << lowest_free;
        rel_mask   = {{(DEPTH-1){1'b0}}, rel_legal} << bus.release_index;
        used_d     = (used_q | alloc_mask) & ~rel_mask;
        count_d    = count_q + COUNT_WIDTH'(xfer) - COUNT_WIDTH'(rel_legal);
        full_d     = (count_d == COUNT_WIDTH'(DEPTH));
        empty_d    = (count_d == '0);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            used_q    <= '0;
            count_q   <= '0;
            full_q    <= 1'b0;
            empty_q   <= 1'b1;
            rel_err_q <= 1'b0;
        end else begin
            used_q    <= used_d;
            count_q   <= count_d;
            full_q    <= full_d;
            empty_q   <= empty_d;
            rel_err_q <= rel_err_d;
        end
    end

    assign bus.allocate_valid = free_found;
    assign bus.allocate_index = lowest_free;
    assign bus.release_error  = rel_err_q;
    assign bus.used_count     = count_q;
    assign bus.full           = full_q;
    assign bus.empty          = empty_q;

endmodule

// File: tb/tb_tag_allocator.sv
// -----------------------------------------------------------------------------
// tb_tag_allocator
// Directed bench for tag_allocator (DEPTH=16) with an in-bench pool model
// (array of used flags, lowest-free search, popcount) checked every cycle,
// plus hand-computed literal expectations for the key scenarios.
// -----------------------------------------------------------------------------
module tb_tag_allocator;
    localparam int DEPTH = 16;
    localparam int IW    = $clog2(DEPTH);
    localparam int CW    = $clog2(DEPTH + 1);

    logic clock = 1'b0;
    logic reset = 1'b0;

    tag_allocator_if #(.DEPTH(DEPTH), .INDEX_WIDTH(IW), .COUNT_WIDTH(CW)) bus ();

    tag_allocator #(.DEPTH(DEPTH), .INDEX_WIDTH(IW), .COUNT_WIDTH(CW)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    // Pool model: which indices are out, and whether the last release was bad.
    bit m_used [DEPTH];
    bit m_err;
    int m_lf;
    bit m_legal;

    function automatic int model_lowest_free();
        for (int i = 0; i < DEPTH; i++) if (!m_used[i]) return i;
        return -1;
    endfunction

    function automatic int model_count();
        int c = 0;
        for (int i = 0; i < DEPTH; i++) c += int'(m_used[i]);
        return c;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) m_used[i] = 1'b0;
            m_err = 1'b0;
        end else begin
            m_lf    = model_lowest_free();
            m_legal = bus.release_enable && (int'(bus.release_index) < DEPTH)
                      && m_used[bus.release_index];
            m_err   = bus.release_enable && !m_legal;
            if (m_legal) m_used[bus.release_index] = 1'b0;
            if (bus.allocate_ready && m_lf >= 0) m_used[m_lf] = 1'b1;
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    bit chk_en = 1'b0;
    always @(negedge clock) begin
        if (chk_en && !reset) begin
            int lf, c;
            lf = model_lowest_free();
            c  = model_count();
            check("m_valid", 32'(bus.allocate_valid), 32'(lf >= 0));
            check("m_index", 32'(bus.allocate_index), (lf >= 0) ? 32'(lf) : 32'd0);
            check("m_count", 32'(bus.used_count), 32'(c));
            check("m_full",  32'(bus.full),  32'(c == DEPTH));
            check("m_empty", 32'(bus.empty), 32'(c == 0));
            check("m_err",   32'(bus.release_error), 32'(m_err));
        end
    end

    // Drive one cycle of inputs mid-period, return just after the edge.
    task automatic step(input logic rdy, input logic ren, input int ridx);
        @(negedge clock);
        #2;
        bus.allocate_ready = rdy;
        bus.release_enable = ren;
        bus.release_index  = IW'(ridx);
        @(posedge clock);
        #1;
    endtask

    initial begin
        bus.allocate_ready = 1'b0;
        bus.release_enable = 1'b0;
        bus.release_index  = '0;
        #1 reset = 1'b1;
        #1;
        check("rst_valid", 32'(bus.allocate_valid), 32'd1);
        check("rst_index", 32'(bus.allocate_index), 32'd0);
        check("rst_count", 32'(bus.used_count), 32'd0);
        check("rst_empty", 32'(bus.empty), 32'd1);
        check("rst_full",  32'(bus.full), 32'd0);
        check("rst_err",   32'(bus.release_error), 32'd0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset  = 1'b0;
        chk_en = 1'b1;

        // Fill the pool in order.
        for (int k = 0; k < DEPTH; k++) begin
            check("fill_index", 32'(bus.allocate_index), 32'(k));
            step(1'b1, 1'b0, 0);
            check("fill_count", 32'(bus.used_count), 32'(k + 1));
        end
        check("fill_full",  32'(bus.full), 32'd1);
        check("fill_valid", 32'(bus.allocate_valid), 32'd0);
        check("full_index", 32'(bus.allocate_index), 32'd0);

        // Ready while nothing is offered has no effect.
        step(1'b1, 1'b0, 0);
        check("noop_count", 32'(bus.used_count), 32'd16);

        // Release 5 while full, then re-take it.
        step(1'b0, 1'b1, 5);
        check("rel5_valid", 32'(bus.allocate_valid), 32'd1);
        check("rel5_index", 32'(bus.allocate_index), 32'd5);
        check("rel5_count", 32'(bus.used_count), 32'd15);
        check("rel5_full",  32'(bus.full), 32'd0);
        step(1'b1, 1'b0, 0);
        check("retake_full", 32'(bus.full), 32'd1);

        // Shrink to 0..3, then transfer 4 and release 1 together.
        for (int k = 4; k < DEPTH; k++) step(1'b0, 1'b1, k);
        check("shrink_count", 32'(bus.used_count), 32'd4);
        check("shrink_index", 32'(bus.allocate_index), 32'd4);
        step(1'b1, 1'b1, 1);
        check("swap_count", 32'(bus.used_count), 32'd4);
        check("swap_index", 32'(bus.allocate_index), 32'd1);
        check("swap_err",   32'(bus.release_error), 32'd0);

        // Empty the pool, then release a free index.
        step(1'b0, 1'b1, 0);
        step(1'b0, 1'b1, 2);
        step(1'b0, 1'b1, 3);
        step(1'b0, 1'b1, 4);
        check("drain_empty", 32'(bus.empty), 32'd1);
        step(1'b0, 1'b1, 9);
        check("bad9_err",   32'(bus.release_error), 32'd1);
        check("bad9_count", 32'(bus.used_count), 32'd0);
        check("bad9_empty", 32'(bus.empty), 32'd1);
        step(1'b0, 1'b0, 0);
        check("bad9_clear", 32'(bus.release_error), 32'd0);

        // Release of the index being handed out in the same cycle.
        step(1'b1, 1'b0, 0);
        step(1'b1, 1'b0, 0);
        check("pre2_index", 32'(bus.allocate_index), 32'd2);
        step(1'b1, 1'b1, 2);
        check("same2_err",   32'(bus.release_error), 32'd1);
        check("same2_count", 32'(bus.used_count), 32'd3);
        check("same2_index", 32'(bus.allocate_index), 32'd3);

        // Double release: first legal, second illegal.
        step(1'b0, 1'b1, 1);
        check("dbl1_err", 32'(bus.release_error), 32'd0);
        step(1'b0, 1'b1, 1);
        check("dbl2_err",   32'(bus.release_error), 32'd1);
        check("dbl2_count", 32'(bus.used_count), 32'd2);

        // Reach 7 used, then reset between edges with a handshake in flight.
        for (int k = 0; k < 5; k++) step(1'b1, 1'b0, 0);
        check("pre_rst_count", 32'(bus.used_count), 32'd7);
        @(negedge clock);
        bus.allocate_ready = 1'b1;
        bus.release_enable = 1'b1;
        bus.release_index  = IW'(3);
        #3 reset = 1'b1;
        #1;
        check("mid_rst_count", 32'(bus.used_count), 32'd0);
        check("mid_rst_empty", 32'(bus.empty), 32'd1);
        check("mid_rst_index", 32'(bus.allocate_index), 32'd0);
        check("mid_rst_valid", 32'(bus.allocate_valid), 32'd1);
        bus.allocate_ready = 1'b0;
        bus.release_enable = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        step(1'b1, 1'b0, 0);
        check("post_rst_count", 32'(bus.used_count), 32'd1);
        check("post_rst_index", 32'(bus.allocate_index), 32'd1);

        // Mixed traffic checked by the per-cycle model comparison.
        for (int k = 0; k < 80; k++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0),
                 int'($urandom_range(0, DEPTH - 1)));
        end
        step(1'b0, 1'b0, 0);
        @(negedge clock);
        chk_en = 1'b0;
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
